conv_weight_loader: RTL and testbench

- Loads one output channel's 5x5 kernel and bias from the parameter memory, then presents them to convolver_complex.
- Assembles the KERN_SIZE weights and the bias into the convolver's wide weights bus and bias word, then drives weight_write with a valid/ack handshake.
- Sits between the parameter memory and convolver_complex as the writer side of the weight_write interface.
- A channel sequencer requests one channel per start pulse.

---
 rtl/conv_weight_loader.sv | 131 +++++++++++++
 tb/tb_conv_weight_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_weight_loader.sv
// conv_weight_loader
//   Fetches one output channel's KERN_SIZE weights and its bias from the
//   parameter memory. It assembles them into the convolver's wide weights bus
//   and bias word, then offers them on the weight_write/weight_ack handshake.
//
// Ports
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start, chan  : load request and channel index, sampled only in IDLE
//   busy         : a load is in progress
//   done         : one-cycle pulse after the convolver accepts the kernel
//   start_err    : one-cycle pulse for a start with an out-of-range channel
//   mem_rd_en    : memory read strobe
//   mem_addr     : memory word address
//   mem_rd_data  : read data, valid one cycle after mem_rd_en
//   weights      : kernel, weight k at [BW*k +: BW]
//   bias         : channel bias
//   weight_write : weights/bias valid to the convolver
//   weight_ack   : convolver accepts (transfer when both high)
module conv_weight_loader #(
  parameter int BW        = 16,
  parameter int KERN_DIM  = 5,
  parameter int KERN_SIZE = KERN_DIM * KERN_DIM,
  parameter int NUM_CHAN  = 20,
  parameter int CHAN_BW   = $clog2(NUM_CHAN),
  parameter int ADDR_BW   = $clog2(NUM_CHAN * (KERN_SIZE + 1))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CHAN_BW-1:0]      chan,
  output logic                    busy,
  output logic                    done,
  output logic                    start_err,
  output logic                    mem_rd_en,
  output logic [ADDR_BW-1:0]      mem_addr,
  input  logic [BW-1:0]           mem_rd_data,
  output logic [BW*KERN_SIZE-1:0] weights,
  output logic [BW-1:0]           bias,
  output logic                    weight_write,
  input  logic                    weight_ack
);

  localparam int RC_BW = $clog2(KERN_SIZE + 1);
  localparam logic [RC_BW-1:0]   LAST_RC    = RC_BW'(KERN_SIZE);
  localparam logic [ADDR_BW-1:0] CHAN_WORDS = ADDR_BW'(KERN_SIZE + 1);
  // One extra bit so NUM_CHAN itself is representable even when it is a power of two.
  localparam logic [CHAN_BW:0]   NUM_CHAN_W = (CHAN_BW + 1)'(NUM_CHAN);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE
  } state_t;

  state_t             state, state_nxt;
  logic               accept, reject;
  logic [ADDR_BW-1:0] base;
  logic [RC_BW-1:0]   rc;
  logic [RC_BW-1:0]   rd_idx;
  logic               rd_vld;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The done cycle is still treated as the tail of the previous load, so a
  // start coinciding with done is dropped even though the state is IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          if ({1'b0, chan} < NUM_CHAN_W) begin
            accept    = 1'b1;
            state_nxt = FETCH;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      FETCH:   if (rc == LAST_RC) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   if (weight_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign mem_rd_en    = (state == FETCH);
  assign weight_write = (state == WRITE);
  assign mem_addr     = base + ADDR_BW'(rc);

  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      rc        <= '0;
      rd_idx    <= '0;
      rd_vld    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      weights   <= '0;
      bias      <= '0;
    end else begin
      done      <= (state == WRITE) && weight_ack;
      start_err <= reject;

      if (accept) begin
        base <= ADDR_BW'(chan) * CHAN_WORDS;
        rc   <= '0;
      end else if (state == FETCH && rc != LAST_RC) begin
        rc   <= rc + RC_BW'(1);
      end

      // Read data returns one cycle after the strobe; steer it with the
      // index that was on the address bus at that time.
      rd_vld <= mem_rd_en;
      rd_idx <= rc;
      if (rd_vld) begin
        for (int unsigned k = 0; k < KERN_SIZE; k++) begin
          if (rd_idx == RC_BW'(k)) weights[BW*k +: BW] <= mem_rd_data;
        end
        if (rd_idx == LAST_RC) bias <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_conv_weight_loader.sv
module tb_conv_weight_loader;

  localparam int BW  = 16;
  localparam int KD  = 5;
  localparam int KS  = KD * KD;
  localparam int CW  = 5;
  localparam int AW  = 10;
  localparam int WW  = BW * KS;

  logic          clk = 1'b0;
  logic          reset, start, weight_ack;
  logic [CW-1:0] chan;
  logic          busy, done, start_err, mem_rd_en, weight_write;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_rd_data, bias;
  logic [WW-1:0] weights;

  logic [BW-1:0] mem [0:1023];

  typedef struct {
    logic [WW-1:0] w;
    logic [BW-1:0] b;
  } xfer_t;

  logic [AW-1:0] addr_q[$];
  xfer_t         xfer_q[$];
  xfer_t         got_x;
  logic [WW-1:0] exp_w;
  logic [BW-1:0] exp_b;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int done_exp    = 0;

  conv_weight_loader #(
    .BW       (BW),
    .KERN_DIM (KD),
    .NUM_CHAN (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .chan         (chan),
    .busy         (busy),
    .done         (done),
    .start_err    (start_err),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .weights      (weights),
    .bias         (bias),
    .weight_write (weight_write),
    .weight_ack   (weight_ack)
  );

  always #5 clk = ~clk;

  // Parameter memory: one-cycle read latency, junk when not reading.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;

  task automatic chk1(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every read address and every transfer is popped
  // and compared when the DUT produces it.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (mem_rd_en) begin
      vectors++;
      assert (addr_q.size() != 0) else begin
        miscompares++;
        $error("FAIL rd_unexpected observed=%0h expected=none", mem_addr);
      end
      if (addr_q.size() != 0) chkw("rd_addr", WW'(mem_addr), WW'(addr_q.pop_front()));
    end
    if (weight_write && weight_ack) begin
      vectors++;
      assert (xfer_q.size() != 0) else begin
        miscompares++;
        $error("FAIL xfer_unexpected observed=%0h expected=none", bias);
      end
      if (xfer_q.size() != 0) begin
        got_x = xfer_q.pop_front();
        chkw("xfer_weights", weights, got_x.w);
        chkw("xfer_bias", WW'(bias), WW'(got_x.b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input int ch);
    int    base;
    xfer_t x;
    base = ch * (KS + 1);
    for (int k = 0; k <= KS; k++) addr_q.push_back(AW'(base + k));
    for (int k = 0; k < KS; k++) x.w[BW*k +: BW] = mem[base + k];
    x.b   = mem[base + KS];
    exp_w = x.w;
    exp_b = x.b;
    xfer_q.push_back(x);
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_start_err"}, start_err, 1'b0);
    chk1({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk1({tag, "_ww"}, weight_write, 1'b0);
    chkw({tag, "_addr"}, WW'(mem_addr), '0);
    chkw({tag, "_weights"}, weights, '0);
    chkw({tag, "_bias"}, WW'(bias), '0);
  endtask

  // Starts at cycle 0 (start driven now), ends at the cycle after done.
  task automatic load(input int ch, input int hold, input bit spurious);
    expect_load(ch);
    chan       = CW'(ch);
    start      = 1'b1;
    weight_ack = (hold == 0);
    step();
    start = 1'b0;
    chk1("busy_c1", busy, 1'b1);
    chk1("start_err_c1", start_err, 1'b0);
    for (int c = 1; c <= 27; c++) begin
      chk1("rd_en_window", mem_rd_en, c <= 26);
      chk1("ww_early", weight_write, 1'b0);
      chk1("busy_fetch", busy, 1'b1);
      if (spurious && c == 5) begin
        start = 1'b1;
        chan  = CW'(7);
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk1("ww_bp", weight_write, 1'b1);
      chkw("weights_bp", weights, exp_w);
      chkw("bias_bp", WW'(bias), WW'(exp_b));
      chk1("done_bp", done, 1'b0);
      step();
    end
    weight_ack = 1'b1;
    chk1("ww_write", weight_write, 1'b1);
    chk1("busy_write", busy, 1'b1);
    step();
    chk1("done_pulse", done, 1'b1);
    chk1("busy_done", busy, 1'b0);
    chk1("ww_done", weight_write, 1'b0);
    chkw("weights_held", weights, exp_w);
    chkw("bias_held", WW'(bias), WW'(exp_b));
    done_exp++;
    if (spurious) begin
      start = 1'b1;
      chan  = CW'(9);
    end
    step();
    start = 1'b0;
    chk1("done_one_cycle", done, 1'b0);
    chk1("busy_after", busy, 1'b0);
    chk1("rd_en_after", mem_rd_en, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    chan       = '0;
    weight_ack = 1'b0;
    for (int n = 0; n < 1024; n++) mem[n] = BW'(n);
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    // Basic load, then last channel started on the cycle after done.
    load(0, 0, 1'b0);
    load(19, 0, 1'b0);

    // Reset in the middle of a fetch aborts without a done pulse.
    expect_load(3);
    chan       = CW'(3);
    start      = 1'b1;
    weight_ack = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    addr_q.delete();
    xfer_q.delete();
    chk_zero("reset_mid");
    reset = 1'b0;
    step();
    step();
    chk1("no_done_abort", done, 1'b0);

    // Fresh load with starts during FETCH and on the done cycle, then one
    // on the following cycle.
    load(3, 0, 1'b1);
    load(11, 0, 1'b0);

    // Out-of-range channels, then a valid start right after.
    chan  = CW'(31);
    start = 1'b1;
    step();
    chan = CW'(20);
    chk1("start_err_31", start_err, 1'b1);
    chk1("busy_err_31", busy, 1'b0);
    step();
    start = 1'b0;
    chk1("start_err_20", start_err, 1'b1);
    chk1("busy_err_20", busy, 1'b0);
    chk1("rd_en_err", mem_rd_en, 1'b0);
    load(5, 0, 1'b0);

    // Random memory contents with convolver backpressure.
    for (int n = 0; n < 1024; n++) mem[n] = BW'($urandom);
    load(12, 7, 1'b0);
    load(19, 2, 1'b0);

    repeat (3) step();
    chkw("addr_q_empty", WW'(addr_q.size()), '0);
    chkw("xfer_q_empty", WW'(xfer_q.size()), '0);
    chkw("done_count", WW'(done_seen), WW'(done_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
